// File: rtl/instr_loader.sv
// Byte-stream program loader: length header + payload packed into 32-bit instruction-memory writes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
//   state | meaning
//   IDLE  | after reset, waiting for start_i
//   LEN   | collecting the 4-byte little-endian length header
//   DATA  | packing payload bytes into words, issuing writes
//   CSUM  | waiting for the checksum byte (LOADER_CHECKSUM_EN only)
//   DONE  | load succeeded, CPU released from reset
//   ERROR | length too large or checksum mismatch
module instr_loader #(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0,
  parameter int                         MAX_BYTES     = 65536
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      byte_valid_i,
  input  logic [7:0]                byte_i,
  output logic                      byte_ready_o,
  output logic                      we_o,
  output logic [ADDRESS_WIDTH-1:0]  waddr_o,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      cpu_rst_no
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERROR} state_t;
`endif

  localparam logic [32:0] MAX_LEN = 33'(MAX_BYTES);

  state_t                     state;
  logic [31:0]                len_q;
  logic [31:0]                remain;
  logic [1:0]                 lane;
  logic [DATA_WIDTH-1:0]      acc;
  logic [ADDRESS_WIDTH-1:0]   word_idx;
  logic                       active_q;
  logic                       done_q;
  logic                       err_q;
  logic                       we_q;
  logic [ADDRESS_WIDTH-1:0]   waddr_q;
  logic [DATA_WIDTH-1:0]      wdata_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                 csum;
`endif

  logic [31:0]                len_full;
  logic [DATA_WIDTH-1:0]      acc_upd;

  // Lanes not yet written stay zero, so a partial final word needs no masking.
  always_comb begin
    len_full = {byte_i, len_q[31:8]};
    acc_upd  = acc;
    acc_upd[{lane, 3'b000} +: 8] = byte_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      len_q    <= '0;
      remain   <= '0;
      lane     <= '0;
      acc      <= '0;
      word_idx <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            state    <= S_LEN;
            len_q    <= '0;
            remain   <= '0;
            lane     <= '0;
            acc      <= '0;
            word_idx <= '0;
            active_q <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        S_LEN: begin
          if (byte_valid_i) begin
            len_q <= len_full;
            lane  <= lane + 2'd1;
            if (lane == 2'd3) begin
              if (len_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                state    <= S_CSUM;
`else
                state    <= S_DONE;
                active_q <= 1'b0;
                done_q   <= 1'b1;
`endif
              end else if ({1'b0, len_full} > MAX_LEN) begin
                state    <= S_ERROR;
                active_q <= 1'b0;
                err_q    <= 1'b1;
              end else begin
                state  <= S_DATA;
                remain <= len_full;
              end
            end
          end
        end
        S_DATA: begin
          if (byte_valid_i) begin
            remain <= remain - 32'd1;
`ifdef LOADER_CHECKSUM_EN
            csum   <= csum ^ byte_i;
`endif
            if (lane == 2'd3 || remain == 32'd1) begin
              we_q     <= 1'b1;
              waddr_q  <= BASE_ADDR + {word_idx[ADDRESS_WIDTH-3:0], 2'b00};
              wdata_q  <= acc_upd;
              word_idx <= word_idx + 1'b1;
              acc      <= '0;
              lane     <= '0;
            end else begin
              acc  <= acc_upd;
              lane <= lane + 2'd1;
            end
            if (remain == 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state    <= S_CSUM;
`else
              state    <= S_DONE;
              active_q <= 1'b0;
              done_q   <= 1'b1;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (byte_valid_i) begin
            active_q <= 1'b0;
            if (byte_i == csum) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state <= S_ERROR;
              err_q <= 1'b1;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign byte_ready_o = active_q;
  assign busy_o       = active_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign cpu_rst_no   = done_q;
  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus randomized loads against a packing model.
// Exercises the checksum path when LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;
  localparam int MAX_B = 65536;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_ready_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] wdata_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        cpu_rst_no;

  instr_loader #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .BASE_ADDR     (32'h0),
    .MAX_BYTES     (MAX_B)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_i       (byte_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .cpu_rst_no   (cpu_rst_no)
  );

  always #5 clk_i = ~clk_i;

  int total  = 0;
  int passes = 0;

  logic [7:0]  pl[$];
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];

  always @(negedge clk_i) if (we_o === 1'b1) obs_q.push_back({waddr_o, wdata_o});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic idle(input int n);
    byte_valid_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid_i = 1'b1;
    byte_i = b;
    while (byte_ready_o !== 1'b1 && n < 16) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 16) begin
      total++;
      $error("FAIL ready_timeout: got byte_ready_o=%b expected 1", byte_ready_o);
    end
    @(negedge clk_i);
  endtask

  task automatic fill(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  // gap_mode: 0 back-to-back, 1 random idles, 2 two idle cycles before payload byte 2
  task automatic run_load(input int len, input int gap_mode, input int start_at,
                          input int csum_sel, input string tag);
    logic [31:0] l;
    logic [31:0] word;
    logic        ok;
    int          nw;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  x;
    logic [7:0]  cb;
`endif
    l = 32'(len);
    obs_q.delete();
    exp_q.delete();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    chk({tag, "_busy"}, 64'(busy_o), 64'd1);
    chk({tag, "_cpurst_hold"}, 64'({done_o, err_o, cpu_rst_no}), 64'd0);
    for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8]);
    byte_valid_i = 1'b0;
    if (l > 32'(MAX_B)) begin
      chk({tag, "_err"}, 64'(err_o), 64'd1);
      chk({tag, "_cpurst_err"}, 64'({cpu_rst_no, done_o, busy_o}), 64'd0);
      idle(3);
      chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'd0);
      return;
    end
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
`endif
    for (int i = 0; i < len; i++) begin
      if (gap_mode == 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (gap_mode == 2 && i == 2) idle(2);
      if (i == start_at) start_i = 1'b1;
      send_byte(pl[i]);
      start_i = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      x = x ^ pl[i];
`endif
    end
    ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    cb = (csum_sel < 0) ? x : 8'(csum_sel);
    send_byte(cb);
    ok = (cb == x);
`endif
    byte_valid_i = 1'b0;
    chk({tag, "_done"}, 64'(done_o), 64'(ok));
    chk({tag, "_errflag"}, 64'(err_o), 64'(!ok));
    chk({tag, "_cpurst"}, 64'(cpu_rst_no), 64'(ok));
    chk({tag, "_idle"}, 64'(busy_o), 64'd0);
`ifndef LOADER_CHECKSUM_EN
    if (len > 0) chk({tag, "_lastwe"}, 64'(we_o), 64'd1);
`endif
    idle(2);
    nw = (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      word = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < len) word = word | (32'(pl[4*w+b]) << (8 * b));
      exp_q.push_back({32'(4 * w), word});
    end
    chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int w = 0; w < nw && w < obs_q.size(); w++) chk({tag, "_write"}, obs_q[w], exp_q[w]);
  endtask

  initial begin
    int len;
    repeat (2) @(negedge clk_i);
    chk("reset_outputs", {56'(we_o), byte_ready_o, busy_o, done_o, err_o, cpu_rst_no},
        64'd0);
    chk("reset_bus", {waddr_o, wdata_o}, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    pl = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    run_load(8, 0, -1, -1, "prog");
    if (obs_q.size() == 2) begin
      chk("prog_w0_const", obs_q[0], {32'h0, 32'h00100513});
      chk("prog_w1_const", obs_q[1], {32'h4, 32'h00200593});
    end

    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(5, 0, -1, -1, "len5");
    if (obs_q.size() == 2) begin
      chk("len5_w0_const", obs_q[0], {32'h0, 32'hDDCCBBAA});
      chk("len5_w1_const", obs_q[1], {32'h4, 32'h000000EE});
    end

    run_load(32'h00010004, 0, -1, -1, "toolong");
    run_load(32'h00010001, 0, -1, -1, "maxplus1");

    pl = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    run_load(8, 2, 5, -1, "gapstart");
    if (obs_q.size() == 2) begin
      chk("gap_w0_const", obs_q[0], {32'h0, 32'h00100513});
      chk("gap_w1_const", obs_q[1], {32'h4, 32'h00200593});
    end

    // Reset after 6 of 8 payload bytes.
    obs_q.delete();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(pl[i]);
    byte_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_outputs", {56'(we_o), byte_ready_o, busy_o, done_o, err_o, cpu_rst_no},
        64'd0);
    chk("midrst_bus", {waddr_o, wdata_o}, 64'd0);
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("midrst_nwrites", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() >= 1) chk("midrst_w0", obs_q[0], {32'h0, 32'h00100513});
    run_load(8, 0, -1, -1, "afterrst");

`ifdef LOADER_CHECKSUM_EN
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(4, 0, -1, 8'h04, "csum_ok");
    run_load(4, 0, -1, 8'h05, "csum_bad");
    if (obs_q.size() == 1) chk("csum_bad_w0_const", obs_q[0], {32'h0, 32'h04030201});
    pl.delete();
    run_load(0, 0, -1, 8'h00, "len0_csum");
`else
    pl.delete();
    run_load(0, 0, -1, -1, "len0");
`endif

    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 13);
      fill(len);
      run_load(len, t % 2, -1, -1, "rand");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
